// File: rtl/fp_div_pkg.sv
// -----------------------------------------------------------------------------
// fp_div_pkg
// Shared types and constants for the FP divider operand feeder.
//   fp32_t     : raw IEEE-754 single-precision word
//   fp_pair_t  : one {dividend, divisor} table entry
//   state_t    : feeder FSM states
//   VEC_A/B    : fixed operand table (TABLE_LEN entries)
// -----------------------------------------------------------------------------
package fp_div_pkg;

    typedef logic [31:0] fp32_t;

    typedef struct packed {
        fp32_t a;
        fp32_t b;
    } fp_pair_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        GAP,
        DONE
    } state_t;

    localparam int TABLE_LEN   = 8;
    localparam int TABLE_IDX_W = 3;

    // Dividends: 6.0, 1.0, -10.0, 0.0, 1.0, +inf, qNaN, 100.0
    localparam fp32_t VEC_A [TABLE_LEN] = '{
        32'h40C0_0000, 32'h3F80_0000, 32'hC120_0000, 32'h0000_0000,
        32'h3F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 32'h42C8_0000
    };

    // Divisors: 2.0, 3.0, 4.0, 5.0, 0.0, 2.0, 1.0, -0.5
    localparam fp32_t VEC_B [TABLE_LEN] = '{
        32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000,
        32'h0000_0000, 32'h4000_0000, 32'h3F80_0000, 32'hBF00_0000
    };

endpackage

// File: rtl/fp_div_vec_rom.sv
// -----------------------------------------------------------------------------
// fp_div_vec_rom
// Combinational index -> {A, B} lookup over the package operand table.
// Indices beyond the table length wrap modulo TABLE_LEN.
// Ports:
//   idx_i   in   IDX_W   table index
//   pair_o  out  64      {dividend, divisor} at idx_i
// -----------------------------------------------------------------------------
module fp_div_vec_rom
    import fp_div_pkg::*;
#(
    parameter int IDX_W = 3
) (
    input  logic [IDX_W-1:0] idx_i,
    output fp_pair_t         pair_o
);

    logic [TABLE_IDX_W-1:0] entry;

    // NOTE: the table is a constant, so there is nothing to reset here; only
    // the feeder's registered copy of the data carries a reset value.
    always_comb begin
        entry    = TABLE_IDX_W'(32'(idx_i));
        pair_o.a = VEC_A[entry];
        pair_o.b = VEC_B[entry];
    end

endmodule

// File: rtl/fp_div_operand_feeder.sv
// -----------------------------------------------------------------------------
// fp_div_operand_feeder
// Walks the fixed operand table and presents each dividend/divisor pair on two
// independent AXI4-Stream channels, honouring each tready separately. A pair
// completes once both beats have been accepted (in any order, or together).
//
// Build option: define FP_DIV_FEEDER_LOOP_EN to wrap to index 0 after the last
// pair and keep issuing forever (DONE never reached). Undefined: one pass per
// start, then DONE until the next start.
//
// Ports:
//   clk              in   1      clock, posedge
//   rstn             in   1      synchronous active-low reset
//   start            in   1      begin a pass (honoured in IDLE / DONE only)
//   s_axis_a_tdata   out  32     dividend
//   s_axis_a_tvalid  out  1      dividend valid
//   s_axis_a_tready  in   1      dividend accepted
//   s_axis_b_tdata   out  32     divisor
//   s_axis_b_tvalid  out  1      divisor valid
//   s_axis_b_tready  in   1      divisor accepted
//   idx_out          out  IDX_W  index of pair being issued
//   busy             out  1      high in ISSUE or GAP
//   done             out  1      high in DONE
// -----------------------------------------------------------------------------
module fp_div_operand_feeder
    import fp_div_pkg::*;
#(
    parameter int NUM_VEC    = 8,
    parameter int GAP_CYCLES = 0
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       start,
    output logic [31:0]                s_axis_a_tdata,
    output logic                       s_axis_a_tvalid,
    input  logic                       s_axis_a_tready,
    output logic [31:0]                s_axis_b_tdata,
    output logic                       s_axis_b_tvalid,
    input  logic                       s_axis_b_tready,
    output logic [$clog2(NUM_VEC)-1:0] idx_out,
    output logic                       busy,
    output logic                       done
);

    localparam int IDX_W = $clog2(NUM_VEC);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_VEC - 1);

    // Counter runs 0 .. GAP_CYCLES-1 while in GAP.
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             a_sent_q, a_sent_d;
    logic             b_sent_q, b_sent_d;
    fp32_t            a_data_q, b_data_q;
    logic             load;
    logic             a_hs, b_hs, pair_done;
    fp_pair_t         rom_pair;

    // The ROM looks up the *next* index so the registered tdata is already
    // correct on the first cycle tvalid is asserted for that pair.
    fp_div_vec_rom #(.IDX_W(IDX_W)) u_rom (
        .idx_i  (idx_d),
        .pair_o (rom_pair)
    );

    assign s_axis_a_tvalid = (state_q == ISSUE) && !a_sent_q;
    assign s_axis_b_tvalid = (state_q == ISSUE) && !b_sent_q;
    assign s_axis_a_tdata  = a_data_q;
    assign s_axis_b_tdata  = b_data_q;
    assign idx_out         = idx_q;
    assign busy            = (state_q == ISSUE) || (state_q == GAP);
    assign done            = (state_q == DONE);

    assign a_hs      = s_axis_a_tvalid && s_axis_a_tready;
    assign b_hs      = s_axis_b_tvalid && s_axis_b_tready;
    // A beat accepted this very cycle counts the same as one accepted earlier.
    assign pair_done = (a_sent_q || a_hs) && (b_sent_q || b_hs);

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        gap_cnt_d = gap_cnt_q;
        a_sent_d  = a_sent_q;
        b_sent_d  = b_sent_q;
        load      = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = ISSUE;
                    idx_d   = '0;
                    load    = 1'b1;
                end
            end

            ISSUE: begin
                if (pair_done) begin
                    a_sent_d = 1'b0;
                    b_sent_d = 1'b0;
                    if (idx_q == IDX_LAST) begin
`ifdef FP_DIV_FEEDER_LOOP_EN
                        idx_d   = '0;
                        load    = 1'b1;
                        state_d = (GAP_CYCLES > 0) ? GAP : ISSUE;
`else
                        state_d = DONE;
`endif
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        load    = 1'b1;
                        state_d = (GAP_CYCLES > 0) ? GAP : ISSUE;
                    end
                end else begin
                    a_sent_d = a_sent_q || a_hs;
                    b_sent_d = b_sent_q || b_hs;
                end
            end

            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d   = ISSUE;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples
    // the pre-edge values; reset is synchronous, checked inside the clocked block.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            gap_cnt_q <= '0;
            a_sent_q  <= 1'b0;
            b_sent_q  <= 1'b0;
            a_data_q  <= '0;
            b_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            gap_cnt_q <= gap_cnt_d;
            a_sent_q  <= a_sent_d;
            b_sent_q  <= b_sent_d;
            if (load) begin
                a_data_q <= rom_pair.a;
                b_data_q <= rom_pair.b;
            end
        end
    end

endmodule

// File: tb/tb_fp_div_operand_feeder.sv
// -----------------------------------------------------------------------------
// tb_fp_div_operand_feeder
// Two feeder instances share clock, reset and tready: dut_z (GAP_CYCLES=0)
// and dut_g (GAP_CYCLES=2). 'sel' chooses which one receives start and is
// observed. Expected behaviour comes from a transaction-level model: per-channel
// beat counts, the pair index is the number of completed pairs, and a channel
// may present a beat only when it is not ahead of the other channel.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fp_div_operand_feeder;

    localparam int NUM_VEC    = 8;
    localparam int GAP_G      = 2;
    localparam int BUDGET     = 2000;
    localparam int LOOP_PAIRS = 2 * NUM_VEC + 3;
`ifdef FP_DIV_FEEDER_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    // Independent copy of the expected operand table.
    localparam logic [31:0] TB_A [NUM_VEC] = '{
        32'h40C00000, 32'h3F800000, 32'hC1200000, 32'h00000000,
        32'h3F800000, 32'h7F800000, 32'h7FC00000, 32'h42C80000
    };
    localparam logic [31:0] TB_B [NUM_VEC] = '{
        32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
        32'h00000000, 32'h40000000, 32'h3F800000, 32'hBF000000
    };

    logic clk = 1'b0;
    logic rstn, start, sel, a_ready, b_ready;

    logic [31:0] z_a_data, z_b_data, g_a_data, g_b_data;
    logic        z_a_valid, z_b_valid, g_a_valid, g_b_valid;
    logic [2:0]  z_idx, g_idx;
    logic        z_busy, z_done, g_busy, g_done;

    logic [31:0] o_a_data, o_b_data;
    logic        o_a_valid, o_b_valid, o_busy, o_done;
    logic [2:0]  o_idx;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fp_div_operand_feeder #(.NUM_VEC(NUM_VEC), .GAP_CYCLES(0)) dut_z (
        .clk(clk), .rstn(rstn), .start(start && !sel),
        .s_axis_a_tdata(z_a_data), .s_axis_a_tvalid(z_a_valid), .s_axis_a_tready(a_ready),
        .s_axis_b_tdata(z_b_data), .s_axis_b_tvalid(z_b_valid), .s_axis_b_tready(b_ready),
        .idx_out(z_idx), .busy(z_busy), .done(z_done)
    );

    fp_div_operand_feeder #(.NUM_VEC(NUM_VEC), .GAP_CYCLES(GAP_G)) dut_g (
        .clk(clk), .rstn(rstn), .start(start && sel),
        .s_axis_a_tdata(g_a_data), .s_axis_a_tvalid(g_a_valid), .s_axis_a_tready(a_ready),
        .s_axis_b_tdata(g_b_data), .s_axis_b_tvalid(g_b_valid), .s_axis_b_tready(b_ready),
        .idx_out(g_idx), .busy(g_busy), .done(g_done)
    );

    assign o_a_data  = sel ? g_a_data  : z_a_data;
    assign o_b_data  = sel ? g_b_data  : z_b_data;
    assign o_a_valid = sel ? g_a_valid : z_a_valid;
    assign o_b_valid = sel ? g_b_valid : z_b_valid;
    assign o_idx     = sel ? g_idx     : z_idx;
    assign o_busy    = sel ? g_busy    : z_busy;
    assign o_done    = sel ? g_done    : z_done;

    task automatic pulse_reset();
        @(negedge clk);
        rstn = 1'b0; start = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // Idle-state checks shared by the reset scenarios.
    task automatic expect_idle(input string tag);
        vectors++; if (o_a_valid !== 1'b0) begin miscompares++; $display("FAIL %s a_tvalid got=%b exp=0", tag, o_a_valid); end
        vectors++; if (o_b_valid !== 1'b0) begin miscompares++; $display("FAIL %s b_tvalid got=%b exp=0", tag, o_b_valid); end
        vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL %s busy got=%b exp=0", tag, o_busy); end
        vectors++; if (o_done !== 1'b0) begin miscompares++; $display("FAIL %s done got=%b exp=0", tag, o_done); end
        vectors++; if (o_idx !== 3'd0) begin miscompares++; $display("FAIL %s idx got=%0d exp=0", tag, o_idx); end
        vectors++; if (o_a_data !== 32'h0) begin miscompares++; $display("FAIL %s a_tdata got=%h exp=0", tag, o_a_data); end
        vectors++; if (o_b_data !== 32'h0) begin miscompares++; $display("FAIL %s b_tdata got=%h exp=0", tag, o_b_data); end
    endtask

    task automatic test_reset();
        sel = 1'b0; rstn = 1'b0; start = 1'b1; a_ready = 1'b1; b_ready = 1'b1;
        repeat (10) @(negedge clk);
        expect_idle("reset");
        start = 1'b0; a_ready = 1'b0; b_ready = 1'b0; rstn = 1'b1;
        @(negedge clk);
        expect_idle("reset_release");
    endtask

    // One pass against the model. pct_*: tready probability; b_hold: cycles
    // b_tready is forced low at the start; poke: random start during the pass;
    // b2b: also check the end-to-end pass time.
    task automatic run_pass(input string tag, input bit use_gap, input int pct_a, input int pct_b,
                            input int b_hold, input bit poke, input bit b2b);
        int a_cnt = 0, b_cnt = 0, pairs, new_pairs, gap_left = 0, gap;
        int dut_a_hs = 0, dut_b_hs = 0, first_cyc = -1, done_cyc = -1;
        bit fin, in_gap, exp_av, exp_bv, ended = 1'b0;
        logic [2:0] exp_idx;
        gap = use_gap ? GAP_G : 0;
        sel = use_gap;
        @(negedge clk);
        start = 1'b1; a_ready = 1'b0; b_ready = 1'b0;
        for (int cyc = 0; cyc < BUDGET && !ended; cyc++) begin
            @(negedge clk);
            start   = 1'b0;
            pairs   = (a_cnt < b_cnt) ? a_cnt : b_cnt;
            fin     = !LOOP_EN && (pairs == NUM_VEC);
            in_gap  = (gap_left > 0);
            exp_av  = !fin && !in_gap && (a_cnt <= b_cnt);
            exp_bv  = !fin && !in_gap && (b_cnt <= a_cnt);
            exp_idx = fin ? 3'(NUM_VEC - 1) : 3'(pairs % NUM_VEC);
            if (first_cyc < 0 && o_a_valid) first_cyc = cyc;
            if (done_cyc < 0 && o_done) done_cyc = cyc;

            vectors++; if (o_a_valid !== exp_av) begin miscompares++; $display("FAIL %s a_tvalid cyc=%0d got=%b exp=%b", tag, cyc, o_a_valid, exp_av); end
            vectors++; if (o_b_valid !== exp_bv) begin miscompares++; $display("FAIL %s b_tvalid cyc=%0d got=%b exp=%b", tag, cyc, o_b_valid, exp_bv); end
            vectors++; if (o_idx !== exp_idx) begin miscompares++; $display("FAIL %s idx cyc=%0d got=%0d exp=%0d", tag, cyc, o_idx, exp_idx); end
            vectors++; if (o_busy !== !fin) begin miscompares++; $display("FAIL %s busy cyc=%0d got=%b exp=%b", tag, cyc, o_busy, !fin); end
            vectors++; if (o_done !== fin) begin miscompares++; $display("FAIL %s done cyc=%0d got=%b exp=%b", tag, cyc, o_done, fin); end
            if (exp_av) begin
                vectors++;
                if (o_a_data !== TB_A[a_cnt % NUM_VEC]) begin miscompares++; $display("FAIL %s a_tdata cyc=%0d got=%h exp=%h", tag, cyc, o_a_data, TB_A[a_cnt % NUM_VEC]); end
            end
            if (exp_bv) begin
                vectors++;
                if (o_b_data !== TB_B[b_cnt % NUM_VEC]) begin miscompares++; $display("FAIL %s b_tdata cyc=%0d got=%h exp=%h", tag, cyc, o_b_data, TB_B[b_cnt % NUM_VEC]); end
            end

            if (fin || (LOOP_EN && pairs >= LOOP_PAIRS)) begin
                ended = 1'b1;
            end else begin
                a_ready = ($urandom_range(99) < 32'(pct_a));
                b_ready = (cyc >= b_hold) && ($urandom_range(99) < 32'(pct_b));
                if (poke) start = 1'($urandom_range(1));
                if (o_a_valid && a_ready) dut_a_hs++;
                if (o_b_valid && b_ready) dut_b_hs++;
                @(posedge clk);
                if (exp_av && a_ready) a_cnt++;
                if (exp_bv && b_ready) b_cnt++;
                new_pairs = (a_cnt < b_cnt) ? a_cnt : b_cnt;
                if (in_gap) gap_left--;
                else if (gap > 0 && new_pairs > pairs && (LOOP_EN || new_pairs < NUM_VEC)) gap_left = gap;
            end
        end
        start = 1'b0; a_ready = 1'b0; b_ready = 1'b0;

        vectors++;
        if (!ended) begin miscompares++; $display("FAIL %s timeout pairs a=%0d b=%0d exp=%0d", tag, a_cnt, b_cnt, NUM_VEC); end
`ifndef FP_DIV_FEEDER_LOOP_EN
        vectors++; if (dut_a_hs != NUM_VEC) begin miscompares++; $display("FAIL %s a_handshakes got=%0d exp=%0d", tag, dut_a_hs, NUM_VEC); end
        vectors++; if (dut_b_hs != NUM_VEC) begin miscompares++; $display("FAIL %s b_handshakes got=%0d exp=%0d", tag, dut_b_hs, NUM_VEC); end
        if (b2b) begin
            vectors++;
            if (done_cyc - first_cyc != NUM_VEC + (NUM_VEC - 1) * gap) begin
                miscompares++;
                $display("FAIL %s pass_time got=%0d exp=%0d", tag, done_cyc - first_cyc, NUM_VEC + (NUM_VEC - 1) * gap);
            end
        end
`else
        pulse_reset();
`endif
    endtask

    task automatic test_back_to_back();  run_pass("b2b",    1'b0, 100, 100, 0, 1'b0, 1'b1); endtask
    task automatic test_skewed_ready();  run_pass("skew",   1'b0, 100, 100, 3, 1'b0, 1'b0); endtask
    task automatic test_gap();           run_pass("gap",    1'b1, 100, 100, 0, 1'b0, 1'b1); endtask

    task automatic test_random();
        run_pass("rand0", 1'b0, 70, 40, 0, 1'b1, 1'b0);
        run_pass("rand1", 1'b1, 50, 80, 0, 1'b1, 1'b0);
        run_pass("rand2", 1'b0, 25, 25, 0, 1'b1, 1'b0);
        run_pass("rand3", 1'b1, 35, 60, 2, 1'b1, 1'b0);
    endtask

    task automatic test_mid_reset();
        bit hit = 1'b0;
        sel = 1'b0;
        @(negedge clk);
        start = 1'b1; a_ready = 1'b1; b_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            if (o_idx == 3'd3) hit = 1'b1;
            else @(negedge clk);
        end
        vectors++;
        if (!hit) begin miscompares++; $display("FAIL mid_reset wait_idx3 got=%0d exp=3", o_idx); end
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1; a_ready = 1'b0; b_ready = 1'b0;
        expect_idle("mid_reset");
        @(negedge clk);
        expect_idle("mid_reset_hold");
        // Fresh start must reissue pair 0.
        run_pass("after_reset", 1'b0, 100, 100, 0, 1'b0, 1'b1);
    endtask

    // Default build: previous pass left DONE, so start here reissues pair 0.
    // Loop build: the model expects wrap-around to pair 0 with done held low.
    task automatic test_restart();
        run_pass("restart", 1'b0, 100, 100, 0, 1'b0, 1'b1);
        run_pass("restart_rand", 1'b0, 60, 60, 0, 1'b1, 1'b0);
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; sel = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
        test_reset();
        test_back_to_back();
        test_skewed_ready();
        test_gap();
        test_random();
        test_mid_reset();
        test_restart();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
